// File: rtl/id_ex_stage.sv
// ID/EX pipeline register for the mips32 core. It resolves the destination register and
// detects load-use and branch-operand hazards, stalling upstream while it feeds bubbles to EX.
module id_ex_stage #(
    parameter int DATA_WIDTH   = 32,
    parameter int CONTROL_SIZE = 8
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    flush,
    input  logic [CONTROL_SIZE-1:0] id_control,
    input  logic [1:0]              id_compareCode,
    input  logic [1:0]              id_branchSrc,
    input  logic [DATA_WIDTH-1:0]   id_pc4,
    input  logic [DATA_WIDTH-1:0]   id_rsData,
    input  logic [DATA_WIDTH-1:0]   id_rtData,
    input  logic [DATA_WIDTH-1:0]   id_imm,
    input  logic [4:0]              id_rs,
    input  logic [4:0]              id_rt,
    input  logic [4:0]              id_rd,
    input  logic [5:0]              id_func,
    input  logic                    mem_memRead,
    input  logic [4:0]              mem_writeReg,
    output logic                    stall,
    output logic [CONTROL_SIZE-1:0] ex_control,
    output logic [DATA_WIDTH-1:0]   ex_pc4,
    output logic [DATA_WIDTH-1:0]   ex_rsData,
    output logic [DATA_WIDTH-1:0]   ex_rtData,
    output logic [DATA_WIDTH-1:0]   ex_imm,
    output logic [4:0]              ex_rs,
    output logic [4:0]              ex_rt,
    output logic [4:0]              ex_rd,
    output logic [5:0]              ex_func,
    output logic [4:0]              ex_writeReg,
    output logic [15:0]             stallCount
);

    logic [CONTROL_SIZE-1:0] control_q;
    logic [DATA_WIDTH-1:0]   pc4_q, rsData_q, rtData_q, imm_q;
    logic [4:0]              rs_q, rt_q, rd_q, writeReg_q, writeReg_d;
    logic [5:0]              func_q;
    logic [15:0]             stallCount_q, stallCount_d;

    logic br, br_uses_rt;
    logic hazard_a, hazard_b, hazard_c;
    logic bubble;

    always_comb begin
        writeReg_d = id_rd;
        case (id_control[6:5])
            2'b00:   writeReg_d = id_rd;
            2'b01:   writeReg_d = id_rt;
            2'b10:   writeReg_d = 5'd31;
            default: writeReg_d = 5'd0;
        endcase
    end

    // jr only reads rs; beq/bne read both sources
    assign br         = (id_branchSrc == 2'b10) && (id_compareCode != 2'b00);
    assign br_uses_rt = br && (id_compareCode != 2'b11);

    assign hazard_a = control_q[4] && (writeReg_q != 5'd0) &&
                      ((writeReg_q == id_rs) || (writeReg_q == id_rt));
    assign hazard_b = br && control_q[2] && (writeReg_q != 5'd0) &&
                      ((writeReg_q == id_rs) || (br_uses_rt && (writeReg_q == id_rt)));
    assign hazard_c = br && mem_memRead && (mem_writeReg != 5'd0) &&
                      ((mem_writeReg == id_rs) || (br_uses_rt && (mem_writeReg == id_rt)));

    assign stall        = (hazard_a || hazard_b || hazard_c) && !flush;
    assign bubble       = flush || stall;
    assign stallCount_d = stall ? stallCount_q + 16'd1 : stallCount_q;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            control_q    <= '0;
            pc4_q        <= '0;
            rsData_q     <= '0;
            rtData_q     <= '0;
            imm_q        <= '0;
            rs_q         <= '0;
            rt_q         <= '0;
            rd_q         <= '0;
            func_q       <= '0;
            writeReg_q   <= '0;
            stallCount_q <= '0;
        end else begin
            stallCount_q <= stallCount_d;
            if (bubble) begin
                control_q  <= '0;
                pc4_q      <= '0;
                rsData_q   <= '0;
                rtData_q   <= '0;
                imm_q      <= '0;
                rs_q       <= '0;
                rt_q       <= '0;
                rd_q       <= '0;
                func_q     <= '0;
                writeReg_q <= '0;
            end else begin
                control_q  <= id_control;
                pc4_q      <= id_pc4;
                rsData_q   <= id_rsData;
                rtData_q   <= id_rtData;
                imm_q      <= id_imm;
                rs_q       <= id_rs;
                rt_q       <= id_rt;
                rd_q       <= id_rd;
                func_q     <= id_func;
                writeReg_q <= writeReg_d;
            end
        end
    end

    assign ex_control  = control_q;
    assign ex_pc4      = pc4_q;
    assign ex_rsData   = rsData_q;
    assign ex_rtData   = rtData_q;
    assign ex_imm      = imm_q;
    assign ex_rs       = rs_q;
    assign ex_rt       = rt_q;
    assign ex_rd       = rd_q;
    assign ex_func     = func_q;
    assign ex_writeReg = writeReg_q;
    assign stallCount  = stallCount_q;

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed bench for id_ex_stage: capture, destination resolution, hazard stalls,
// flush priority, register-0 immunity, asynchronous reset and stall-counter wrap.
module tb_id_ex_stage;

    logic        clock = 1'b0;
    logic        reset;
    logic        flush;
    logic [7:0]  id_control;
    logic [1:0]  id_compareCode, id_branchSrc;
    logic [31:0] id_pc4, id_rsData, id_rtData, id_imm;
    logic [4:0]  id_rs, id_rt, id_rd;
    logic [5:0]  id_func;
    logic        mem_memRead;
    logic [4:0]  mem_writeReg;
    logic        stall;
    logic [7:0]  ex_control;
    logic [31:0] ex_pc4, ex_rsData, ex_rtData, ex_imm;
    logic [4:0]  ex_rs, ex_rt, ex_rd, ex_writeReg;
    logic [5:0]  ex_func;
    logic [15:0] stallCount;

    int tests = 0;
    int fails = 0;

    id_ex_stage #(.DATA_WIDTH(32), .CONTROL_SIZE(8)) dut (
        .clock(clock), .reset(reset), .flush(flush),
        .id_control(id_control), .id_compareCode(id_compareCode), .id_branchSrc(id_branchSrc),
        .id_pc4(id_pc4), .id_rsData(id_rsData), .id_rtData(id_rtData), .id_imm(id_imm),
        .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd), .id_func(id_func),
        .mem_memRead(mem_memRead), .mem_writeReg(mem_writeReg),
        .stall(stall), .ex_control(ex_control), .ex_pc4(ex_pc4), .ex_rsData(ex_rsData),
        .ex_rtData(ex_rtData), .ex_imm(ex_imm), .ex_rs(ex_rs), .ex_rt(ex_rt), .ex_rd(ex_rd),
        .ex_func(ex_func), .ex_writeReg(ex_writeReg), .stallCount(stallCount)
    );

    always #5 clock = ~clock;

    task automatic set_idle();
        flush = 0; id_control = 0; id_compareCode = 0; id_branchSrc = 0;
        id_pc4 = 0; id_rsData = 0; id_rtData = 0; id_imm = 0;
        id_rs = 0; id_rt = 0; id_rd = 0; id_func = 0;
        mem_memRead = 0; mem_writeReg = 0;
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset();
        set_idle();
        reset = 0;
        step();
        reset = 1;
        #1;
    endtask

    task automatic test_reset();
        do_reset();
        id_control = 8'h22; id_rt = 5'd4; id_rd = 5'd6; id_pc4 = 32'h100;
        step();
        tests++;
        if (ex_control !== 8'h22) begin fails++; $display("FAIL reset_pre_ctrl: got %h want 22", ex_control); end
        #2;
        reset = 0;
        #1;
        tests++;
        if ({ex_control, ex_pc4, ex_rsData, ex_rtData, ex_imm, ex_rs, ex_rt, ex_rd, ex_func, ex_writeReg} !== '0)
        begin fails++; $display("FAIL reset_ex_clear: ctrl=%h pc4=%h wr=%h", ex_control, ex_pc4, ex_writeReg); end
        tests++;
        if (stallCount !== 16'd0) begin fails++; $display("FAIL reset_count: got %0d want 0", stallCount); end
        tests++;
        if (stall !== 1'b0) begin fails++; $display("FAIL reset_stall: got %b want 0", stall); end
        #2;
        reset = 1;
        set_idle();
        step();
    endtask

    task automatic test_capture();
        do_reset();
        id_control = 8'h40; id_rd = 5'd5; id_rs = 5'd1; id_rt = 5'd2;
        id_pc4 = 32'h0000_1004; id_rsData = 32'hDEAD_BEEF; id_rtData = 32'h1234_5678;
        id_imm = 32'hFFFF_FFF0; id_func = 6'h20;
        step();
        tests++;
        if (ex_writeReg !== 5'd31) begin fails++; $display("FAIL cap_dest_31: got %0d want 31", ex_writeReg); end
        tests++;
        if (ex_control !== 8'h40 || ex_pc4 !== 32'h0000_1004 || ex_rsData !== 32'hDEAD_BEEF ||
            ex_rtData !== 32'h1234_5678 || ex_imm !== 32'hFFFF_FFF0)
        begin fails++; $display("FAIL cap_data: ctrl=%h pc4=%h rs=%h rt=%h imm=%h", ex_control, ex_pc4, ex_rsData, ex_rtData, ex_imm); end
        tests++;
        if (ex_rs !== 5'd1 || ex_rt !== 5'd2 || ex_rd !== 5'd5 || ex_func !== 6'h20)
        begin fails++; $display("FAIL cap_fields: rs=%0d rt=%0d rd=%0d func=%h want 1 2 5 20", ex_rs, ex_rt, ex_rd, ex_func); end
        id_control = 8'h20; id_rt = 5'd7; id_rd = 5'd3;
        step();
        tests++;
        if (ex_writeReg !== 5'd7) begin fails++; $display("FAIL cap_dest_rt: got %0d want 7", ex_writeReg); end
        id_control = 8'h00; id_rd = 5'd9; id_rt = 5'd4;
        step();
        tests++;
        if (ex_writeReg !== 5'd9) begin fails++; $display("FAIL cap_dest_rd: got %0d want 9", ex_writeReg); end
        id_control = 8'h60; id_rd = 5'd11; id_rt = 5'd12;
        step();
        tests++;
        if (ex_writeReg !== 5'd0) begin fails++; $display("FAIL cap_dest_zero: got %0d want 0", ex_writeReg); end
        set_idle();
        step();
    endtask

    task automatic test_load_use();
        do_reset();
        id_control = 8'h3A; id_rt = 5'd8; id_rs = 5'd2;
        #1;
        tests++;
        if (stall !== 1'b0) begin fails++; $display("FAIL lu_nostall_lw: got %b want 0", stall); end
        step();
        set_idle();
        id_control = 8'h04; id_rs = 5'd8; id_rt = 5'd3; id_rd = 5'd10;
        #1;
        tests++;
        if (stall !== 1'b1) begin fails++; $display("FAIL lu_stall: got %b want 1", stall); end
        step();
        tests++;
        if (ex_control !== 8'h00 || stallCount !== 16'd1)
        begin fails++; $display("FAIL lu_bubble: ctrl=%h cnt=%0d want 00 1", ex_control, stallCount); end
        tests++;
        if (stall !== 1'b0) begin fails++; $display("FAIL lu_release: got %b want 0", stall); end
        step();
        tests++;
        if (ex_control !== 8'h04 || ex_writeReg !== 5'd10 || ex_rs !== 5'd8 || stallCount !== 16'd1)
        begin fails++; $display("FAIL lu_capture: ctrl=%h wr=%0d rs=%0d cnt=%0d want 04 10 8 1", ex_control, ex_writeReg, ex_rs, stallCount); end
        set_idle();
        step();
    endtask

    task automatic test_branch_load();
        do_reset();
        id_control = 8'h3A; id_rt = 5'd9;
        step();
        set_idle();
        id_branchSrc = 2'b10; id_compareCode = 2'b01; id_rs = 5'd1; id_rt = 5'd9;
        #1;
        tests++;
        if (stall !== 1'b1) begin fails++; $display("FAIL bl_stall1: got %b want 1", stall); end
        step();
        mem_memRead = 1; mem_writeReg = 5'd9;
        #1;
        tests++;
        if (stall !== 1'b1 || stallCount !== 16'd1)
        begin fails++; $display("FAIL bl_stall2: stall=%b cnt=%0d want 1 1", stall, stallCount); end
        step();
        mem_memRead = 0; mem_writeReg = 0;
        #1;
        tests++;
        if (stall !== 1'b0 || stallCount !== 16'd2 || ex_control !== 8'h00)
        begin fails++; $display("FAIL bl_release: stall=%b cnt=%0d ctrl=%h want 0 2 00", stall, stallCount, ex_control); end
        step();
        tests++;
        if (ex_rt !== 5'd9 || ex_rs !== 5'd1) begin fails++; $display("FAIL bl_capture: rs=%0d rt=%0d want 1 9", ex_rs, ex_rt); end
        set_idle();
        step();
    endtask

    task automatic test_alu_branch();
        do_reset();
        id_control = 8'h04; id_rd = 5'd12;
        step();
        set_idle();
        id_branchSrc = 2'b10; id_compareCode = 2'b11; id_rs = 5'd1; id_rt = 5'd12;
        #1;
        tests++;
        if (stall !== 1'b0) begin fails++; $display("FAIL ab_jr_rt_ignored: got %b want 0", stall); end
        id_compareCode = 2'b10;
        #1;
        tests++;
        if (stall !== 1'b1) begin fails++; $display("FAIL ab_bne_stall: got %b want 1", stall); end
        id_branchSrc = 2'b00;
        #1;
        tests++;
        if (stall !== 1'b0) begin fails++; $display("FAIL ab_not_regsrc: got %b want 0", stall); end
        id_branchSrc = 2'b10;
        step();
        tests++;
        if (stall !== 1'b0 || stallCount !== 16'd1)
        begin fails++; $display("FAIL ab_one_cycle: stall=%b cnt=%0d want 0 1", stall, stallCount); end
        set_idle();
        step();
    endtask

    task automatic test_reg0_flush();
        do_reset();
        id_control = 8'h3A; id_rt = 5'd0;
        step();
        set_idle();
        id_control = 8'h04; id_rs = 5'd0; id_rt = 5'd0;
        #1;
        tests++;
        if (stall !== 1'b0) begin fails++; $display("FAIL r0_nostall: got %b want 0", stall); end
        set_idle();
        id_control = 8'h3A; id_rt = 5'd8;
        step();
        set_idle();
        id_control = 8'h04; id_rs = 5'd8; id_rd = 5'd10; flush = 1;
        #1;
        tests++;
        if (stall !== 1'b0) begin fails++; $display("FAIL fl_stall: got %b want 0", stall); end
        step();
        tests++;
        if (ex_control !== 8'h00 || ex_writeReg !== 5'd0 || stallCount !== 16'd0)
        begin fails++; $display("FAIL fl_bubble: ctrl=%h wr=%0d cnt=%0d want 00 0 0", ex_control, ex_writeReg, stallCount); end
        set_idle();
        step();
    endtask

    task automatic test_reset_mid_stall();
        do_reset();
        id_control = 8'h3A; id_rt = 5'd8;
        step();
        set_idle();
        id_rs = 5'd8;
        #1;
        reset = 0;
        #1;
        tests++;
        if (stall !== 1'b0 || ex_control !== 8'h00 || stallCount !== 16'd0)
        begin fails++; $display("FAIL rst_mid_stall: stall=%b ctrl=%h cnt=%0d want 0 00 0", stall, ex_control, stallCount); end
        reset = 1;
        set_idle();
        step();
    endtask

    task automatic test_wrap();
        do_reset();
        step();
        id_branchSrc = 2'b10; id_compareCode = 2'b01; id_rs = 5'd5;
        mem_memRead = 1; mem_writeReg = 5'd5;
        repeat (65535) @(posedge clock);
        #1;
        tests++;
        if (stallCount !== 16'hFFFF || stall !== 1'b1)
        begin fails++; $display("FAIL wrap_full: cnt=%h stall=%b want ffff 1", stallCount, stall); end
        step();
        tests++;
        if (stallCount !== 16'h0000) begin fails++; $display("FAIL wrap_zero: got %h want 0000", stallCount); end
        set_idle();
        step();
    endtask

    initial begin
        reset = 1;
        set_idle();
        #2;
        test_reset();
        test_capture();
        test_load_use();
        test_branch_load();
        test_alu_branch();
        test_reg0_flush();
        test_reset_mid_stall();
        test_wrap();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
